// File: rtl/phys_reg_free_list_pkg.sv
// phys_reg_free_list_pkg: shared preg types, default sizes and a prefix popcount helper
package phys_reg_free_list_pkg;
  localparam int FL_PHY_REG_NUM = 64;
  localparam int FL_DECODE_WIDTH = 4;
  localparam int FL_COMMIT_WIDTH = 4;
  localparam int FL_PW = $clog2(FL_PHY_REG_NUM);
  typedef logic [FL_PW-1:0] preg_t;
  typedef logic [FL_PW:0] fl_ptr_t;
  function automatic logic [7:0] popcount_prefix(input logic [31:0] vec, input int idx);
    logic [7:0] c;
    c = '0;
    for (int j = 0; j < 32; j++) if (j < idx) c = c + 8'(vec[j]);
    return c;
  endfunction
endpackage

// File: rtl/phys_reg_free_list_prefix_popcount.sv
// fl_prefix_popcount: per-lane count of set bits below each lane, plus the total
module fl_prefix_popcount import phys_reg_free_list_pkg::*; #(
  parameter int W = 4,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]         vec_i,
  output logic [W-1:0][OW-1:0] off_o,
  output logic [OW-1:0]        total_o
);
  always_comb begin
    for (int i = 0; i < W; i++) off_o[i] = OW'(popcount_prefix(32'(vec_i), i));
    total_o = OW'(popcount_prefix(32'(vec_i), W));
  end
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical registers with speculative head,
// architectural head for flush rollback, and in-order commit frees at the tail.
module phys_reg_free_list import phys_reg_free_list_pkg::*; #(
  parameter int PHY_REG_NUM = FL_PHY_REG_NUM,
  parameter int DECODE_WIDTH = FL_DECODE_WIDTH,
  parameter int COMMIT_WIDTH = FL_COMMIT_WIDTH,
  parameter int PW = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DECODE_WIDTH-1:0]          alloc_req_i,
  output logic                             alloc_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]  preg_o,
  input  logic [COMMIT_WIDTH-1:0]          commit_dest_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_ppdst_valid_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_ppdst_i,
  input  logic                             restore_i,
  output logic [PW:0]                      free_count_o,
  output logic                             empty_o
);
  localparam int AW = $clog2(DECODE_WIDTH + 1);
  localparam int CW = $clog2(COMMIT_WIDTH + 1);
  logic [PW-1:0] fl_q [PHY_REG_NUM];
  logic [PW-1:0] fl_d [PHY_REG_NUM];
  logic [PW:0] head_q, head_d, tail_q, tail_d, arch_head_q, arch_head_d;
  logic [PW:0] free_count_q, free_count_d, count;
  logic empty_q, empty_d, fire;
  logic [DECODE_WIDTH-1:0][AW-1:0] a_off;
  logic [AW-1:0] a_total;
  logic [COMMIT_WIDTH-1:0][CW-1:0] f_off;
  logic [CW-1:0] f_total;

  fl_prefix_popcount #(.W(DECODE_WIDTH)) u_alloc_pc (
    .vec_i(alloc_req_i), .off_o(a_off), .total_o(a_total)
  );
  fl_prefix_popcount #(.W(COMMIT_WIDTH)) u_free_pc (
    .vec_i(commit_ppdst_valid_i), .off_o(f_off), .total_o(f_total)
  );

  // Readiness looks only at registered state so it never waits on the request lanes
  assign count = tail_q - head_q;
  assign alloc_ready_o = (count >= (PW+1)'(DECODE_WIDTH)) & ~restore_i;
  assign fire = alloc_ready_o & |alloc_req_i;
  assign free_count_o = free_count_q;
  assign empty_o = empty_q;

  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) preg_o[i] = fl_q[head_q[PW-1:0] + PW'(a_off[i])];
  end

  always_comb begin
    fl_d = fl_q;
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (commit_ppdst_valid_i[k]) fl_d[tail_q[PW-1:0] + PW'(f_off[k])] = commit_ppdst_i[k];
    tail_d = tail_q + (PW+1)'(f_total);
    arch_head_d = arch_head_q + (PW+1)'(popcount_prefix(32'(commit_dest_i), COMMIT_WIDTH));
    head_d = restore_i ? arch_head_d : fire ? head_q + (PW+1)'(a_total) : head_q;
    free_count_d = tail_d - head_d;
    empty_d = free_count_d == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REG_NUM; k++) fl_q[k] <= PW'(k);
      head_q <= '0;
      arch_head_q <= '0;
      tail_q <= (PW+1)'(PHY_REG_NUM);
      free_count_q <= (PW+1)'(PHY_REG_NUM);
      empty_q <= 1'b0;
    end else begin
      fl_q <= fl_d;
      head_q <= head_d;
      arch_head_q <= arch_head_d;
      tail_q <= tail_d;
      free_count_q <= free_count_d;
      empty_q <= empty_d;
    end
  end

  a_no_free_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(|commit_ppdst_valid_i && count == (PW+1)'(PHY_REG_NUM)));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    free_count_d <= (PW+1)'(PHY_REG_NUM));
  a_arch_behind_head: assert property (@(posedge clk) disable iff (!rst_n)
    (PW+1)'(head_d - arch_head_d) <= (PW+1)'(PHY_REG_NUM));
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed scenarios plus a randomized golden-model run with a
// scoreboard that rejects any preg granted twice while outstanding.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;
  localparam int N = 64, DW = 4, CW = 4, PW = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] alloc_req_i = '0;
  logic alloc_ready_o;
  logic [DW-1:0][PW-1:0] preg_o;
  logic [CW-1:0] commit_dest_i = '0, commit_ppdst_valid_i = '0;
  logic [CW-1:0][PW-1:0] commit_ppdst_i = '0;
  logic restore_i = 1'b0;
  logic [PW:0] free_count_o;
  logic empty_o;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk(clk), .rst_n(rst_n), .alloc_req_i(alloc_req_i), .alloc_ready_o(alloc_ready_o),
    .preg_o(preg_o), .commit_dest_i(commit_dest_i),
    .commit_ppdst_valid_i(commit_ppdst_valid_i), .commit_ppdst_i(commit_ppdst_i),
    .restore_i(restore_i), .free_count_o(free_count_o), .empty_o(empty_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req_i = '0;
    commit_dest_i = '0;
    commit_ppdst_valid_i = '0;
    commit_ppdst_i = '0;
    restore_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_count", free_count_o, 64);
    chk("rst_empty", empty_o, 0);
    chk("rst_ready", alloc_ready_o, 1);
    alloc_req_i = 4'b1111;
    #1;
    for (int i = 0; i < DW; i++) chk("full_grant", preg_o[i], i);
    clk1();
    alloc_req_i = '0;
    #1;
    chk("count_after4", free_count_o, 60);
    alloc_req_i = 4'b1111;
    #1;
    chk("head_at4", preg_o[0], 4);

    do_reset();
    alloc_req_i = 4'b1010;
    #1;
    chk("sparse_l1", preg_o[1], 0);
    chk("sparse_l3", preg_o[3], 1);
    clk1();
    alloc_req_i = 4'b0001;
    #1;
    chk("sparse_next", preg_o[0], 2);
    alloc_req_i = '0;
    #1;
    chk("sparse_count", free_count_o, 62);

    do_reset();
    alloc_req_i = 4'b1111;
    repeat (15) clk1();
    alloc_req_i = 4'b0001;
    clk1();
    alloc_req_i = '0;
    #1;
    chk("drain_count", free_count_o, 3);
    chk("drain_notready", alloc_ready_o, 0);
    alloc_req_i = 4'b0001;
    #1;
    chk("drain_preg", preg_o[0], 61);
    clk1();
    chk("stall_hold", free_count_o, 3);
    commit_ppdst_valid_i = 4'b0001;
    commit_ppdst_i[0] = 6'd7;
    commit_dest_i = 4'b0001;
    #1;
    chk("nobypass", alloc_ready_o, 0);
    clk1();
    commit_ppdst_valid_i = '0;
    commit_dest_i = '0;
    #1;
    chk("refill_ready", alloc_ready_o, 1);
    chk("refill_count", free_count_o, 4);
    alloc_req_i = 4'b1111;
    #1;
    chk("refill_l0", preg_o[0], 61);
    chk("refill_l3", preg_o[3], 7);
    clk1();
    alloc_req_i = '0;
    #1;
    chk("empty_flag", empty_o, 1);
    chk("empty_count", free_count_o, 0);
    chk("empty_notready", alloc_ready_o, 0);

    do_reset();
    alloc_req_i = 4'b1111;
    repeat (2) clk1();
    alloc_req_i = '0;
    commit_dest_i = 4'b0111;
    clk1();
    commit_dest_i = '0;
    restore_i = 1'b1;
    alloc_req_i = 4'b1111;
    #1;
    chk("restore_noalloc", alloc_ready_o, 0);
    clk1();
    restore_i = 1'b0;
    alloc_req_i = '0;
    #1;
    chk("restore_count", free_count_o, 61);
    alloc_req_i = 4'b0001;
    #1;
    chk("restore_grant", preg_o[0], 3);
    alloc_req_i = '0;

    do_reset();
    alloc_req_i = 4'b1111;
    repeat (2) clk1();
    alloc_req_i = '0;
    restore_i = 1'b1;
    commit_dest_i = 4'b0011;
    commit_ppdst_valid_i = 4'b0001;
    commit_ppdst_i[0] = 6'd40;
    clk1();
    restore_i = 1'b0;
    commit_dest_i = '0;
    commit_ppdst_valid_i = '0;
    #1;
    chk("rf_count", free_count_o, 63);
    alloc_req_i = 4'b0001;
    #1;
    chk("rf_head", preg_o[0], 2);
    alloc_req_i = '0;
    commit_ppdst_valid_i = 4'b0001;
    commit_ppdst_i[0] = 6'd50;
    clk1();
    commit_ppdst_valid_i = '0;
    #1;
    chk("rf_full", free_count_o, 64);
    alloc_req_i = 4'b1111;
    repeat (15) clk1();
    #1;
    chk("rf_wrap40", preg_o[2], 40);
    chk("rf_wrap50", preg_o[3], 50);
    clk1();
    alloc_req_i = '0;
    #1;
    chk("rf_empty", empty_o, 1);

    do_reset();
    begin : rnd
      int mfl [N];
      bit outs [N];
      int live [$];
      int mh, mt, ma;
      for (int k = 0; k < N; k++) begin
        mfl[k] = k;
        outs[k] = 1'b0;
      end
      mh = 0;
      mt = N;
      ma = 0;
      for (int c = 0; c < 200; c++) begin
        int nd, off, p;
        logic [DW-1:0] req;
        req = DW'($urandom_range(0, 15));
        alloc_req_i = req;
        commit_ppdst_valid_i = '0;
        for (int k = 0; k < CW; k++)
          if (live.size() > 0 && $urandom_range(0, 2) != 0) begin
            commit_ppdst_valid_i[k] = 1'b1;
            commit_ppdst_i[k] = PW'(live.pop_front());
          end
        nd = (mh - ma) < CW ? (mh - ma) : CW;
        commit_dest_i = CW'((1 << nd) - 1);
        #1;
        chk("rnd_ready", alloc_ready_o, (mt - mh) >= DW);
        if ((mt - mh) >= DW && req != '0) begin
          off = 0;
          for (int i = 0; i < DW; i++)
            if (req[i]) begin
              p = mfl[(mh + off) % N];
              chk("rnd_preg", preg_o[i], p);
              chk("rnd_dup", outs[preg_o[i]], 0);
              outs[p] = 1'b1;
              live.push_back(p);
              off++;
            end
          mh += off;
        end
        off = 0;
        for (int k = 0; k < CW; k++)
          if (commit_ppdst_valid_i[k]) begin
            mfl[(mt + off) % N] = int'(commit_ppdst_i[k]);
            outs[commit_ppdst_i[k]] = 1'b0;
            off++;
          end
        mt += off;
        ma += nd;
        clk1();
        chk("rnd_count", free_count_o, mt - mh);
        chk("rnd_empty", empty_o, mt == mh);
        chk("rnd_wrap", dut.head_q[PW], (mh / N) % 2);
      end
      alloc_req_i = '0;
      commit_dest_i = '0;
      commit_ppdst_valid_i = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
